// File: rtl/chattering_multi.sv
// chattering_multi: multi-channel synchronizer + N-consecutive-sample debounce filter with edge pulses
module chattering_multi #(
   parameter int P_CH        = 4,
   parameter int P_SAMPL_BIT = 32,
   parameter int P_MATCH_BIT = 32,
   parameter int P_SYNC      = 2,
   parameter int P_INIT      = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [P_CH-1:0]        sig_i,
   input  logic [P_CH-1:0]        en,
   input  logic [P_SAMPL_BIT-1:0] sample,
   input  logic [P_MATCH_BIT-1:0] count,
   output logic [P_CH-1:0]        sig_o,
   output logic [P_CH-1:0]        rise_o,
   output logic [P_CH-1:0]        fall_o,
   output logic                   change_o
);
   localparam logic L_INIT = (P_INIT != 0);
   logic [P_SAMPL_BIT-1:0]            scount;
   logic                              tick;
   logic [P_CH-1:0][P_SYNC-1:0]       sync;
   logic [P_CH-1:0][P_MATCH_BIT-1:0]  mcount, mcount_nx;
   logic [P_CH-1:0]                   s, sw;
   // Compare one bit wider so scount+1 never overflows; a lowered sample ticks immediately.
   assign tick = ({1'b0, scount} + (P_SAMPL_BIT+1)'(1)) >= {1'b0, sample};
   // shared prescaler
   always_ff @(posedge clk)
      scount <= (reset || tick) ? '0 : scount + P_SAMPL_BIT'(1);
   // per-channel filter decision: switch when the run of differing samples reaches count
   always_comb begin
      s         = '0;
      sw        = '0;
      mcount_nx = mcount;
      for (int i = 0; i < P_CH; i++) begin
         s[i]         = sync[i][P_SYNC-1];
         sw[i]        = tick && en[i] && (s[i] != sig_o[i]) &&
                        (({1'b0, mcount[i]} + (P_MATCH_BIT+1)'(1)) >= {1'b0, count});
         mcount_nx[i] = !tick ? mcount[i] :
                        (!en[i] || (s[i] == sig_o[i]) || sw[i]) ? '0 : mcount[i] + P_MATCH_BIT'(1);
      end
   end
   // synchronizer chains, match counters, debounced levels and registered event pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         sync     <= {(P_CH*P_SYNC){L_INIT}};
         mcount   <= '0;
         sig_o    <= {P_CH{L_INIT}};
         rise_o   <= '0;
         fall_o   <= '0;
         change_o <= 1'b0;
      end else begin
         for (int i = 0; i < P_CH; i++) sync[i] <= {sync[i][P_SYNC-2:0], sig_i[i]};
         mcount   <= mcount_nx;
         sig_o    <= (sig_o & ~sw) | (s & sw);
         rise_o   <= sw & s;
         fall_o   <= sw & ~s;
         change_o <= |sw;
      end
   end
endmodule

// File: doc/chattering_multi.md
Name: chattering_multi

Overview:
- Multi-channel parametrised debouncer: P_CH asynchronous inputs (switches/buttons), each with a synchronizer and an N-consecutive-sample stability filter.
- One prescaler shared by all channels.
- Per-channel enable, configurable reset level, and registered one-cycle rise/fall event pulses for downstream edge consumers (interrupt/event logic).

Parameters:
P_CH, 4, number of independent channels (>=1)
P_SAMPL_BIT, 32, width of sampling-period input and prescaler counter
P_MATCH_BIT, 32, width of match-count input and per-channel match counters
P_SYNC, 2, synchronizer flip-flop stages per channel (>=2)
P_INIT, 0, reset level of every synchronizer stage and every sig_o bit (0 or 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
sig_i  input  P_CH  raw asynchronous inputs
en  input  P_CH  per-channel filter enable
sample  input  P_SAMPL_BIT  sampling period in clk cycles
count  input  P_MATCH_BIT  consecutive differing samples required to switch output
sig_o  output  P_CH  debounced levels (registered)
rise_o  output  P_CH  one-cycle pulse when sig_o[i] goes 0->1
fall_o  output  P_CH  one-cycle pulse when sig_o[i] goes 1->0
change_o  output  1  one-cycle pulse, OR of all rise_o/fall_o bits, same cycle

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset=1 at an edge forces: prescaler=0, all match counters=0, all sync stages=P_INIT, sig_o={P_CH{P_INIT}}, rise_o=fall_o=0, change_o=0.
  - Reset mid-operation discards pending counts; no pulse is generated by reset.
- Prescaler:
  - tick = (scount+1 >= sample), compared at P_SAMPL_BIT+1 bits (no overflow).
  - On tick: scount<=0; otherwise scount<=scount+1.
  - sample=0 or 1 gives tick every cycle; sample=4 gives tick every 4th cycle.
  - Lowering sample below the current scount gives tick on the next cycle (>= compare), then normal period.
- Synchronizer:
  - s[i] = output of a P_SYNC-stage shift chain on sig_i[i].
  - Only s[i] is used by the filter; raw sig_i is never compared directly.
- Per channel i, evaluated only on tick cycles (non-tick cycles hold mcount[i] and sig_o[i]):
  - en[i]=0: mcount[i]<=0; sig_o[i] holds; no pulses.
  - en[i]=1 and s[i]==sig_o[i]: mcount[i]<=0 (a glitch restarts the run).
  - en[i]=1 and s[i]!=sig_o[i] and mcount[i]+1 >= count (P_MATCH_BIT+1-bit compare): sig_o[i]<=s[i]; mcount[i]<=0; rise_o[i] or fall_o[i] asserted on the same edge, per direction.
  - Otherwise: mcount[i]<=mcount[i]+1.
  - count=0 or 1: one differing sample switches the output.
  - mcount never wraps; it is bounded by count.
- Pulses:
  - rise_o, fall_o and change_o are registered.
  - They are high for exactly the cycle after the edge where sig_o changes, i.e. coincident with the new sig_o value.
  - All are cleared on every other cycle.
  - Several channels may pulse in the same cycle.
- Live configuration:
  - sample and count are used live.
  - Changing count mid-run applies to the next tick comparison.
- Channels are fully independent except for the shared tick.
- Latency for a clean input step: P_SYNC cycles to s, plus wait to next tick, plus (count-1) further ticks; sig_o updates on that count-th differing tick.

Test Plan:
- Reset: P_INIT=0, reset high 3 cycles with sig_i=4'hF -> sig_o=0, rise_o=fall_o=0, change_o=0 throughout reset and on the first cycle after release.
- Clean step: P_CH=4, sample=4, count=3, en=4'hF, sig_i[0] 0->1 held -> sig_o[0]=1 on the 3rd tick after s[0] rises; rise_o[0] and change_o high exactly one cycle; other bits unchanged.
- Glitch rejection: same config, sig_i[1] high for 8 cycles (2 ticks) then low -> sig_o[1] stays 0, no pulse. Then 1,1,0,1,1,1 sampled at ticks -> switch only after the final three consecutive 1s.
- Enable mask: en=4'b1011, all sig_i toggle 0->1 -> sig_o=4'b1011 after filter; channel 2 stays 0 until en[2]=1, then switches 3 ticks later.
- Fast mode and falling edge: sample=0, count=0, sig_i[3] 1->0 (sig_o[3]=1) -> sig_o[3]=0 on the cycle after s[3] falls; fall_o[3] pulses one cycle.
- Reset mid-count: sig_i[0] differing for 2 ticks with count=3, assert reset one cycle -> mcount cleared; after release the full 3 ticks are required again, and no pulse occurs during reset.
